// File: rtl/key_schedule.sv
`default_nettype none
// ============================================================================
//  Module   : key_schedule
//  Purpose  : Iterative AES-128 key expansion. A start request in IDLE
//             latches the cipher key and streams round keys 0..10, one per
//             clock, each tagged with its round index and a valid strobe.
//  Ports    : clk, rst_n (async, active low)
//             start, key_in[127:0]        - expansion request / cipher key
//             busy, done                  - EXPAND state / round-10 pulse
//             rk_valid, rk_round[3:0],
//             rk_out[127:0]               - round key stream
//             rd_idx[3:0], rd_key[127:0],
//             keys_ready                  - stored-key read port
//  Macro    : KEY_SCHEDULE_STORE_EN - when defined, an 11x128 register file
//             keeps every produced round key for random-access reads; when
//             undefined rd_key and keys_ready are tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_out,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         keys_ready
);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_EXPAND = 1'b1;
    localparam logic [3:0] c_LAST_RC   = 4'd10;

    // Forward AES S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at bit 8*(255-x)+7, i.e. {~x, 3'b111}.
    function automatic logic [7:0] f_sbox(input logic [7:0] x);
        f_sbox = c_SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] f_rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    f_rcon = 8'h01;
            4'd2:    f_rcon = 8'h02;
            4'd3:    f_rcon = 8'h04;
            4'd4:    f_rcon = 8'h08;
            4'd5:    f_rcon = 8'h10;
            4'd6:    f_rcon = 8'h20;
            4'd7:    f_rcon = 8'h40;
            4'd8:    f_rcon = 8'h80;
            4'd9:    f_rcon = 8'h1b;
            4'd10:   f_rcon = 8'h36;
            default: f_rcon = 8'h00;
        endcase
    endfunction

    logic [0:0]   r_state;
    logic [3:0]   r_rc;
    logic [127:0] r_rk_out;
    logic         r_rk_valid;
    logic         r_done;

    logic [0:0]   w_state_nxt;
    logic [3:0]   w_rc_nxt;
    logic [127:0] w_rk_out_nxt;
    logic         w_rk_valid_nxt;
    logic         w_done_nxt;
    logic         w_load;
    logic         w_step;

    // ------------------------------------------------------------------
    // Next round key from the key currently on rk_out.
    // ------------------------------------------------------------------
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_next_key;
    logic [3:0]   w_rc_inc;

    assign {w_w0, w_w1, w_w2, w_w3} = r_rk_out;
    assign w_rot    = {w_w3[23:0], w_w3[31:24]};
    assign w_rc_inc = r_rc + 4'd1;

    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
        assign w_sub[8*gi +: 8] = f_sbox(w_rot[8*gi +: 8]);
    end

    // Rcon is indexed by the round being produced, not the current one.
    assign w_t        = w_sub ^ {f_rcon(w_rc_inc), 24'h0};
    assign w_n0       = w_w0 ^ w_t;
    assign w_n1       = w_w1 ^ w_n0;
    assign w_n2       = w_w2 ^ w_n1;
    assign w_n3       = w_w3 ^ w_n2;
    assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

    // ------------------------------------------------------------------
    // Control: next-state and next-output decode.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_rc_nxt       = r_rc;
        w_rk_out_nxt   = r_rk_out;
        w_rk_valid_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        w_load         = 1'b0;
        w_step         = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt    = c_ST_EXPAND;
                    w_rc_nxt       = 4'd0;
                    w_rk_out_nxt   = key_in;
                    w_rk_valid_nxt = 1'b1;
                    w_load         = 1'b1;
                end
            end
            c_ST_EXPAND: begin
                w_rc_nxt       = w_rc_inc;
                w_rk_out_nxt   = w_next_key;
                w_rk_valid_nxt = 1'b1;
                w_step         = 1'b1;
                // Leaving on the edge that produces round 10 lets a held
                // start be accepted on the very next edge.
                if (w_rc_inc == c_LAST_RC) begin
                    w_state_nxt = c_ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_rc       <= 4'd0;
            r_rk_out   <= '0;
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rc       <= w_rc_nxt;
            r_rk_out   <= w_rk_out_nxt;
            r_rk_valid <= w_rk_valid_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign busy     = (r_state == c_ST_EXPAND);
    assign done     = r_done;
    assign rk_valid = r_rk_valid;
    assign rk_round = r_rc;
    assign rk_out   = r_rk_out;

    // ------------------------------------------------------------------
    // Optional round-key register file.
    // ------------------------------------------------------------------
`ifdef KEY_SCHEDULE_STORE_EN
    logic [127:0] r_keys [0:10];
    logic         r_keys_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 11; i++) begin
                r_keys[i] <= '0;
            end
            r_keys_ready <= 1'b0;
        end else begin
            // Each key is written at the same edge it appears on rk_out.
            if (w_load || w_step) begin
                r_keys[w_rc_nxt] <= w_rk_out_nxt;
            end
            if (w_load) begin
                r_keys_ready <= 1'b0;
            end else if (w_done_nxt) begin
                r_keys_ready <= 1'b1;
            end
        end
    end

    assign rd_key     = (rd_idx <= c_LAST_RC) ? r_keys[rd_idx] : '0;
    assign keys_ready = r_keys_ready;
`else
    logic w_unused_rd_idx;
    assign w_unused_rd_idx = ^rd_idx;
    assign rd_key          = '0;
    assign keys_ready      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_schedule
//  Purpose  : Self-checking bench for key_schedule. Expected round keys come
//             from an independent GF(2^8) model (S-box derived from the field
//             inverse and affine map) plus published FIPS-197 vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_schedule;

    localparam logic [127:0] c_FIPS   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_OTHER  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_ZERO   = 128'h0;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         rk_valid;
    logic [3:0]   rk_round;
    logic [127:0] rk_out;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         keys_ready;

    key_schedule dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .rk_valid   (rk_valid),
        .rk_round   (rk_round),
        .rk_out     (rk_out),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key),
        .keys_ready (keys_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   rnd;
        logic [127:0] key;
        logic         last;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] model_ks [0:10];
    logic [127:0] captured [0:10];
    int           n_pass  = 0;
    int           n_total = 0;

    // ---------------------------- reference model ----------------------------
    function automatic logic [7:0] m_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = m_xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] b = 8'h01;
        for (int i = 0; i < 254; i++) b = m_gmul(b, x);  // x^254 = x^-1
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    task automatic m_expand(input logic [127:0] key);
        logic [31:0] w0, w1, w2, w3, rot, t;
        logic [7:0]  rc = 8'h01;
        model_ks[0] = key;
        {w0, w1, w2, w3} = key;
        for (int r = 1; r <= 10; r++) begin
            rot = {w3[23:0], w3[31:24]};
            t = {m_sbox(rot[31:24]), m_sbox(rot[23:16]),
                 m_sbox(rot[15:8]),  m_sbox(rot[7:0])} ^ {rc, 24'h0};
            w0 = w0 ^ t;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            model_ks[r] = {w0, w1, w2, w3};
            rc = m_xtime(rc);
        end
    endtask

    task automatic push_expected(input logic [127:0] key);
        exp_t e;
        m_expand(key);
        for (int r = 0; r <= 10; r++) begin
            e.rnd  = 4'(r);
            e.key  = model_ks[r];
            e.last = (r == 10);
            sb.push_back(e);
        end
    endtask

    // --------------------------------- tests ---------------------------------
    task automatic test_reset();
        @(negedge clk);
        n_total++;
        if ({busy, done, rk_valid, rk_round, rk_out, keys_ready} !== '0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {busy, done, rk_valid, rk_round, rk_out, keys_ready});
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({busy, rk_valid, done} !== 3'b000)
            $display("FAIL reset_idle: got %b expected 000", {busy, rk_valid, done});
        else n_pass++;
    endtask

    task automatic test_stream(input string name, input logic [127:0] key,
                               input logic inject, input logic [127:0] other);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        key_in = key;
        push_expected(key);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL %s_sb_empty: got no expected entry at cycle %0d", name, i);
            end else begin
                e = sb.pop_front();
                if ({rk_valid, rk_round, rk_out, done} !== {1'b1, e.rnd, e.key, e.last})
                    $display("FAIL %s_round%0d: got v=%b r=%0d k=%h d=%b expected v=1 r=%0d k=%h d=%b",
                             name, i, rk_valid, rk_round, rk_out, done, e.rnd, e.key, e.last);
                else n_pass++;
            end
            n_total++;
            if (busy !== (i < 10))
                $display("FAIL %s_busy%0d: got %b expected %b", name, i, busy, (i < 10));
            else n_pass++;
            captured[i] = rk_out;
            if (i == 0) start = 1'b0;
            if (inject && i == 2) begin
                start  = 1'b1;
                key_in = other;
            end
            if (inject && i == 3) begin
                start  = 1'b0;
                key_in = key;
            end
        end
        @(negedge clk);
        n_total++;
        if ({rk_valid, done, busy} !== 3'b000)
            $display("FAIL %s_idle_after: got %b expected 000", name, {rk_valid, done, busy});
        else n_pass++;
    endtask

    task automatic test_fips();
        test_stream("fips", c_FIPS, 1'b0, c_ZERO);
        n_total++;
        if ({captured[0], captured[1], captured[2], captured[10]} !==
            {c_FIPS, 128'ha0fafe1788542cb123a339392a6c7605,
             128'hf2c295f27a96b9435935807a7359f67f, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6})
            $display("FAIL fips_vectors: got r1=%h r2=%h r10=%h expected published values",
                     captured[1], captured[2], captured[10]);
        else n_pass++;
    endtask

    task automatic test_zero_key();
        test_stream("zero", c_ZERO, 1'b0, c_ZERO);
        n_total++;
        if ({captured[1], captured[10]} !==
            {128'h62636363626363636263636362636363, 128'hb4ef5bcb3e92e21123e951cf6f8f188e})
            $display("FAIL zero_vectors: got r1=%h r10=%h expected published values",
                     captured[1], captured[10]);
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        test_stream("ignore", c_FIPS, 1'b1, c_OTHER);
        n_total++;
        if (captured[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
            $display("FAIL ignore_r10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", captured[10]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        key_in = c_FIPS;
        push_expected(c_FIPS);
        push_expected(c_OTHER);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL b2b_sb_empty: got no expected entry at cycle %0d", i);
            end else begin
                e = sb.pop_front();
                if ({rk_valid, rk_round, rk_out, done} !== {1'b1, e.rnd, e.key, e.last})
                    $display("FAIL b2b_cycle%0d: got v=%b r=%0d k=%h d=%b expected v=1 r=%0d k=%h d=%b",
                             i, rk_valid, rk_round, rk_out, done, e.rnd, e.key, e.last);
                else n_pass++;
            end
            n_total++;
            if (busy !== (i != 10 && i != 21))
                $display("FAIL b2b_busy%0d: got %b expected %b", i, busy, (i != 10 && i != 21));
            else n_pass++;
            if (i == 0)  key_in = c_OTHER;
            if (i == 11) start  = 1'b0;
        end
        @(negedge clk);
        n_total++;
        if ({rk_valid, busy} !== 2'b00)
            $display("FAIL b2b_idle_after: got %b expected 00", {rk_valid, busy});
        else n_pass++;
    endtask

    task automatic test_async_reset();
        m_expand(c_FIPS);
        @(negedge clk);
        start  = 1'b1;
        key_in = c_FIPS;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
        end
        n_total++;
        if ({rk_round, rk_out} !== {4'd5, model_ks[5]})
            $display("FAIL arst_round5: got r=%0d k=%h expected r=5 k=%h", rk_round, rk_out, model_ks[5]);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, done, rk_valid, rk_round, rk_out, keys_ready} !== '0)
            $display("FAIL arst_immediate: got %h expected 0",
                     {busy, done, rk_valid, rk_round, rk_out, keys_ready});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if ({rk_valid, busy} !== 2'b00)
                $display("FAIL arst_no_resume%0d: got %b expected 00", i, {rk_valid, busy});
            else n_pass++;
        end
        test_stream("after_rst", c_FIPS, 1'b0, c_ZERO);
    endtask

    task automatic test_store();
        m_expand(c_FIPS);
`ifdef KEY_SCHEDULE_STORE_EN
        n_total++;
        if (keys_ready !== 1'b1)
            $display("FAIL store_ready: got %b expected 1", keys_ready);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            n_total++;
            if (rd_key !== ((i <= 10) ? model_ks[i] : 128'h0))
                $display("FAIL store_rd%0d: got %h expected %h", i, rd_key,
                         ((i <= 10) ? model_ks[i] : 128'h0));
            else n_pass++;
        end
        @(negedge clk);
        start  = 1'b1;
        key_in = c_ZERO;
        @(negedge clk);
        start  = 1'b0;
        rd_idx = 4'd0;
        #1;
        n_total++;
        if ({keys_ready, rd_key} !== {1'b0, c_ZERO})
            $display("FAIL store_restart: got ready=%b rd0=%h expected ready=0 rd0=0", keys_ready, rd_key);
        else n_pass++;
        rd_idx = 4'd1;
        #1;
        n_total++;
        if (rd_key !== model_ks[1])
            $display("FAIL store_stale1: got %h expected %h", rd_key, model_ks[1]);
        else n_pass++;
        repeat (10) @(negedge clk);
        m_expand(c_ZERO);
        rd_idx = 4'd10;
        #1;
        n_total++;
        if ({keys_ready, rd_key} !== {1'b1, model_ks[10]})
            $display("FAIL store_reexpand: got ready=%b rd10=%h expected ready=1 rd10=%h",
                     keys_ready, rd_key, model_ks[10]);
        else n_pass++;
`else
        for (int i = 0; i < 16; i += 5) begin
            rd_idx = 4'(i);
            #1;
            n_total++;
            if ({keys_ready, rd_key} !== '0)
                $display("FAIL nostore_rd%0d: got ready=%b key=%h expected 0", i, keys_ready, rd_key);
            else n_pass++;
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        rd_idx = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_fips();
        test_zero_key();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_store();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
